// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, sends start/8 data/parity/stop
// on device-generated clock edges, samples the device ACK and reports completion or timeout.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES     = 2700,
    parameter int FIRST_EDGE_TIMEOUT = 405000,
    parameter int FRAME_TIMEOUT      = 54000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       command_ready,
    input  logic       command_valid,
    input  logic [7:0] command_byte,
    input  logic       command_ack_ready,
    output logic       command_ack_valid,
    output logic       command_ack_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       rx_inhibit,
    output logic [2:0] state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_START   = 3'd2,
        S_SHIFT   = 3'd3,
        S_ACK     = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] FE_LAST  = 20'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [19:0] FR_LAST  = 20'(FRAME_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  byte_q;
    logic        parity_q;
    logic [19:0] cnt_q;
    logic [3:0]  bit_cnt_q;
    logic        clk_s1_q, clk_s2_q, clk_prev_q;
    logic        data_s1_q, data_s2_q;
    logic        clk_drive_q, data_drive_q;
    logic        ack_valid_q, ack_error_q;

    logic [19:0] cnt_d;
    logic [3:0]  bit_cnt_d;
    logic        fall_edge;

    // Both counters saturate at all-ones instead of wrapping.
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 20'd1;
    assign bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + 4'd1;
    assign fall_edge = clk_prev_q & ~clk_s2_q;

    // Handshakes: a command transfers on the rising edge where command_valid && command_ready;
    // a report transfers on the rising edge where command_ack_valid && command_ack_ready.
    // Report payload (command_ack_error) holds steady while command_ack_valid is high.
    assign command_ready      = (state_q == S_IDLE);
    assign rx_inhibit         = (state_q != S_IDLE);
    assign command_ack_valid  = ack_valid_q;
    assign command_ack_error  = ack_error_q;
    assign ps2_clk_drive_low  = clk_drive_q;
    assign ps2_data_drive_low = data_drive_q;
    assign state_dbg_o        = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            parity_q     <= 1'b0;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            clk_drive_q  <= 1'b0;
            data_drive_q <= 1'b0;
            ack_valid_q  <= 1'b0;
            ack_error_q  <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;

            case (state_q)
                S_IDLE: begin
                    if (command_valid) begin
                        byte_q       <= command_byte;
                        parity_q     <= ~^command_byte;
                        cnt_q        <= '0;
                        bit_cnt_q    <= '0;
                        clk_drive_q  <= 1'b1;
                        data_drive_q <= (INH_LAST == 20'd0);
                        state_q      <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    // Data joins the clock low only in the final inhibit cycle.
                    if (cnt_q >= INH_LAST) begin
                        clk_drive_q  <= 1'b0;
                        data_drive_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_START;
                    end else begin
                        cnt_q        <= cnt_d;
                        data_drive_q <= (cnt_d >= INH_LAST);
                    end
                end

                S_START: begin
                    if (fall_edge) begin
                        bit_cnt_q    <= 4'd1;
                        cnt_q        <= '0;
                        data_drive_q <= ~byte_q[0];
                        state_q      <= S_SHIFT;
                    end else if (cnt_q >= FE_LAST) begin
                        data_drive_q <= 1'b0;
                        ack_valid_q  <= 1'b1;
                        ack_error_q  <= 1'b1;
                        state_q      <= S_REPORT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_SHIFT: begin
                    if (cnt_q >= FR_LAST) begin
                        data_drive_q <= 1'b0;
                        ack_valid_q  <= 1'b1;
                        ack_error_q  <= 1'b1;
                        state_q      <= S_REPORT;
                    end else begin
                        cnt_q <= cnt_d;
                        // bit_cnt_q holds the number of edges already seen.
                        if (fall_edge) begin
                            bit_cnt_q <= bit_cnt_d;
                            if (bit_cnt_q <= 4'd7) begin
                                data_drive_q <= ~byte_q[bit_cnt_q[2:0]];
                            end else if (bit_cnt_q == 4'd8) begin
                                data_drive_q <= ~parity_q;
                            end else if (bit_cnt_q == 4'd9) begin
                                data_drive_q <= 1'b0;
                            end else begin
                                data_drive_q <= 1'b0;
                                ack_error_q  <= data_s2_q;
                                state_q      <= S_ACK;
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (cnt_q >= FR_LAST) begin
                        ack_error_q <= 1'b1;
                    end
                    data_drive_q <= 1'b0;
                    ack_valid_q  <= 1'b1;
                    state_q      <= S_REPORT;
                end

                S_REPORT: begin
                    clk_drive_q  <= 1'b0;
                    data_drive_q <= 1'b0;
                    if (command_ack_ready) begin
                        ack_valid_q <= 1'b0;
                        ack_error_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    clk_drive_q  <= 1'b0;
                    data_drive_q <= 1'b0;
                    ack_valid_q  <= 1'b0;
                    ack_error_q  <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: open-collector bus model, device clocking model and a
// scoreboard of expected frames and completion results.
module tb_ps2_command_tx;

    localparam int INH  = 4;
    localparam int FET  = 50;
    localparam int FRT  = 400;
    localparam int HALF = 8;

    logic       clk;
    logic       reset;
    logic       command_ready;
    logic       command_valid;
    logic [7:0] command_byte;
    logic       command_ack_ready;
    logic       command_ack_valid;
    logic       command_ack_error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       rx_inhibit;
    logic [2:0] state_dbg_o;

    logic dev_clk;
    logic dev_data;
    int   cyc;
    int   n_cmp;
    int   n_mis;

    logic [0:0] exp_err_q[$];
    logic [9:0] exp_frame_q[$];

    ps2_command_tx #(
        .INHIBIT_CYCLES(INH),
        .FIRST_EDGE_TIMEOUT(FET),
        .FRAME_TIMEOUT(FRT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .command_ready(command_ready),
        .command_valid(command_valid),
        .command_byte(command_byte),
        .command_ack_ready(command_ack_ready),
        .command_ack_valid(command_ack_valid),
        .command_ack_error(command_ack_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .rx_inhibit(rx_inhibit),
        .state_dbg_o(state_dbg_o)
    );

    // Open-collector lines: either side pulling low wins.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
    assign ps2_data_in = dev_data & ~ps2_data_drive_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        check("ready_before_send", command_ready, 1);
        command_valid = 1'b1;
        command_byte  = b;
        @(negedge clk);
        command_valid = 1'b0;
        exp_err_q.push_back(1'b0);
        exp_frame_q.push_back({1'b1, ~^b, b});
    endtask

    // Entered at the first sample after acceptance; returns at the first released-clock sample.
    task automatic measure_inhibit(input string tag);
        int   n;
        logic early;
        logic dd_last;
        n = 0;
        early = 1'b0;
        dd_last = 1'b0;
        while (ps2_clk_drive_low && n < 100) begin
            n++;
            if (ps2_data_drive_low && n < INH) early = 1'b1;
            dd_last = ps2_data_drive_low;
            @(negedge clk);
        end
        check({tag, "_clk_low_cycles"}, n, INH);
        check({tag, "_data_low_early"}, early, 0);
        check({tag, "_data_low_last"}, dd_last, 1);
        check({tag, "_start_bit"}, ps2_data_drive_low, 1);
    endtask

    task automatic dev_run(input int n_edges, input bit do_ack, output logic [9:0] seen);
        int w;
        seen = '0;
        w = 0;
        while (!(ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("dev_rts_seen", (w < 100), 1);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && do_ack) begin
                dev_data = 1'b0;
                repeat (2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) seen[i-1] = ~ps2_data_drive_low;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [9:0] seen);
        logic [9:0] exp;
        if (exp_frame_q.size() == 0) begin
            check({tag, "_frame_queue_empty"}, 1, 0);
        end else begin
            exp = exp_frame_q.pop_front();
            check({tag, "_frame_bits"}, seen, exp);
        end
    endtask

    task automatic wait_report(input string tag, input bit do_ack, output int at_cyc);
        int   w;
        logic exp;
        w = 0;
        while (!command_ack_valid && w < 1000) begin
            @(negedge clk);
            w++;
        end
        at_cyc = cyc;
        check({tag, "_report_seen"}, (w < 1000), 1);
        if (exp_err_q.size() == 0) begin
            check({tag, "_err_queue_empty"}, 1, 0);
        end else begin
            exp = exp_err_q.pop_front();
            check({tag, "_ack_error"}, command_ack_error, exp);
        end
        check({tag, "_report_clk_rel"}, ps2_clk_drive_low, 0);
        check({tag, "_report_data_rel"}, ps2_data_drive_low, 0);
        check({tag, "_report_not_ready"}, command_ready, 0);
        check({tag, "_report_rx_inhibit"}, rx_inhibit, 1);
        if (do_ack) begin
            command_ack_ready = 1'b1;
            @(negedge clk);
            command_ack_ready = 1'b0;
            check({tag, "_idle_after_ack"}, command_ready, 1);
            check({tag, "_ack_valid_cleared"}, command_ack_valid, 0);
        end
    endtask

    initial begin
        logic [9:0] seen;
        int         rel_cyc;
        int         rep_cyc;
        int         c;
        logic       any_bad;

        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        command_valid = 1'b0;
        command_byte = 8'h00;
        command_ack_ready = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_drive", ps2_clk_drive_low, 0);
        check("rst_data_drive", ps2_data_drive_low, 0);
        check("rst_ack_valid", command_ack_valid, 0);
        check("rst_ack_error", command_ack_error, 0);
        check("rst_rx_inhibit", rx_inhibit, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", command_ready, 1);

        // Device clock edges while idle must not disturb the block
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (4) @(negedge clk);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("idle_edges_ready", command_ready, 1);
        check("idle_edges_inhibit", rx_inhibit, 0);

        // 0xED with a device ACK
        send_cmd(8'hED);
        measure_inhibit("ed");
        dev_run(11, 1'b1, seen);
        check_frame("ed", seen);
        wait_report("ed", 1'b1, rep_cyc);

        // 0x02 with no ACK
        send_cmd(8'h02);
        exp_err_q[exp_err_q.size()-1] = 1'b1;
        measure_inhibit("02");
        dev_run(11, 1'b0, seen);
        check("02_parity_bit", seen[8], 0);
        check_frame("02", seen);
        wait_report("02", 1'b1, rep_cyc);

        // Device never clocks: first-edge timeout
        send_cmd(8'h55);
        exp_err_q[exp_err_q.size()-1] = 1'b1;
        void'(exp_frame_q.pop_back());
        measure_inhibit("noclk");
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!command_ack_valid && c < 200);
        check("noclk_timeout_cycles", c, FET);
        wait_report("noclk", 1'b1, rep_cyc);

        // Device stops after 5 edges: frame timeout
        send_cmd(8'hA3);
        exp_err_q[exp_err_q.size()-1] = 1'b1;
        void'(exp_frame_q.pop_back());
        measure_inhibit("stall");
        rel_cyc = cyc;
        dev_run(5, 1'b0, seen);
        wait_report("stall", 1'b1, rep_cyc);
        check("stall_not_early", (rep_cyc - rel_cyc >= FRT), 1);
        check("stall_not_late", (rep_cyc - rel_cyc <= FRT + 30), 1);

        // Report held while consumer stalls and a new command waits
        send_cmd(8'h3C);
        measure_inhibit("hold");
        dev_run(11, 1'b1, seen);
        check_frame("hold", seen);
        command_valid = 1'b1;
        command_byte = 8'hC4;
        wait_report("hold", 1'b0, rep_cyc);
        any_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!command_ack_valid || command_ready || ps2_clk_drive_low) any_bad = 1'b1;
        end
        check("hold_report_stalled", any_bad, 0);
        command_ack_ready = 1'b1;
        @(negedge clk);
        command_ack_ready = 1'b0;
        check("hold_ready_after_ack", command_ready, 1);
        @(negedge clk);
        command_valid = 1'b0;
        exp_err_q.push_back(1'b0);
        exp_frame_q.push_back({1'b1, ~^8'hC4, 8'hC4});
        check("hold_next_frame_started", ps2_clk_drive_low, 1);
        measure_inhibit("c4");
        dev_run(11, 1'b1, seen);
        check_frame("c4", seen);
        wait_report("c4", 1'b1, rep_cyc);

        // Reset around edge 6 of a frame
        send_cmd(8'h81);
        measure_inhibit("rst");
        dev_run(6, 1'b0, seen);
        reset = 1'b1;
        #1;
        check("midrst_clk_rel", ps2_clk_drive_low, 0);
        check("midrst_data_rel", ps2_data_drive_low, 0);
        check("midrst_ack_valid", command_ack_valid, 0);
        exp_err_q.delete();
        exp_frame_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        any_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (command_ack_valid || ps2_clk_drive_low || ps2_data_drive_low) any_bad = 1'b1;
        end
        check("midrst_quiet_after", any_bad, 0);

        send_cmd(8'h5A);
        measure_inhibit("post");
        dev_run(11, 1'b1, seen);
        check_frame("post", seen);
        wait_report("post", 1'b1, rep_cyc);
        check("scoreboard_drained", exp_err_q.size() + exp_frame_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ps2_command_tx.md
PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2700, meaning the number of cycles the host holds PS/2 clock low before the start bit (100 us at 27 MHz).
REQ-002 SHALL have parameter FIRST_EDGE_TIMEOUT, default 405000, meaning the maximum cycles from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 54000, meaning the maximum cycles from the first falling edge to the ACK sample (2 ms).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port command_ready, output, 1 bit: the block can accept a command byte.
REQ-007 SHALL have port command_valid, input, 1 bit: command_byte is offered.
REQ-008 SHALL have port command_byte, input, 8 bits: the byte to send host-to-device.
REQ-009 SHALL have port command_ack_ready, input, 1 bit: the consumer accepts the completion report.
REQ-010 SHALL have port command_ack_valid, output, 1 bit: a completion report is pending.
REQ-011 SHALL have port command_ack_error, output, 1 bit: the pending report is a failure (timeout or no ACK).
REQ-012 SHALL have port ps2_clk_in, input, 1 bit: the raw PS/2 clock line level.
REQ-013 SHALL have port ps2_data_in, input, 1 bit: the raw PS/2 data line level.
REQ-014 SHALL have port ps2_clk_drive_low, output, 1 bit: 1 pulls the clock line low, 0 releases it.
REQ-015 SHALL have port ps2_data_drive_low, output, 1 bit: 1 pulls the data line low, 0 releases it.
REQ-016 SHALL have port rx_inhibit, output, 1 bit: high whenever the state is not IDLE, telling the scan-code receiver to ignore the lines.

Function
REQ-017 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; "falling edge" means synced clock was 1 last cycle and is 0 this cycle.
REQ-018 SHALL implement the states IDLE, INHIBIT, START, SHIFT, ACK and REPORT.
REQ-019 IDLE: command_ready=1 and both drives=0; on command_valid&&command_ready, SHALL latch the byte and its odd-parity bit (~^byte), clear the counter, and go to INHIBIT.
REQ-020 INHIBIT: ps2_clk_drive_low=1 for exactly INHIBIT_CYCLES cycles; ps2_data_drive_low SHALL also be 1 in the last of those cycles; then go to START.
REQ-021 START: clock released, data held low (start bit); SHALL wait for a falling edge; if FIRST_EDGE_TIMEOUT cycles elapse without one, SHALL go to REPORT with error=1.
REQ-022 SHALL track falling edges in SHIFT with a 4-bit bit counter and a frame timer started at the START-exit edge.
REQ-023 Each falling edge SHALL update the data drive: edges 1-8 present data bits 0-7 (LSB first, drive_low=~bit); edge 9 presents parity; edge 10 presents the stop bit (release); edge 11 enters ACK.
REQ-024 ACK: SHALL sample synced data in the cycle of edge 11; 0 gives error=0, 1 gives error=1; then go to REPORT.
REQ-025 If the frame timer reaches FRAME_TIMEOUT in SHIFT/ACK, SHALL release both lines and go to REPORT with error=1.
REQ-026 REPORT: both drives=0, command_ack_valid=1, command_ack_error stable; SHALL return to IDLE on the cycle command_ack_ready=1; command_ready stays 0 until then.
REQ-027 Edges in IDLE or REPORT SHALL be ignored; command_valid outside IDLE SHALL not be accepted.
REQ-028 Counters SHALL be 20 bits wide, saturate, and never wrap.

Reset
REQ-029 On reset=1, asynchronously: state=IDLE, ps2_clk_drive_low=0, ps2_data_drive_low=0, command_ack_valid=0, command_ack_error=0, rx_inhibit=0, command_ready=1 after deassertion, counters and synchronizers cleared to idle-high line values.
REQ-030 Reset mid-frame SHALL release both lines immediately and discard the byte and any pending report.

Verification (INHIBIT_CYCLES=4, FIRST_EDGE_TIMEOUT=50, FRAME_TIMEOUT=400)
REQ-031 Send 0xED; the device model clocks and ACKs -> clock low exactly 4 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, ack_valid=1 with error=0.
REQ-032 Send 0x02; the device leaves data high at the ACK edge -> parity 0 observed, ack_valid=1 with error=1.
REQ-033 Send a byte; the device never clocks -> error=1 reported 50 cycles after clock release, both drives 0.
REQ-034 The device stops after 5 edges -> error=1 when the frame timer hits 400, lines released.
REQ-035 Hold command_ack_ready=0 for 10 cycles with command_valid=1 -> report held, command_ready=0, no second frame starts; the next frame starts after ack_ready.
REQ-036 Assert reset at edge 6 -> both drives 0 in the same cycle, ack_valid stays 0, and a new command completes normally.
